// File: rtl/sim_ctrl_pkg.sv
// rtl/sim_ctrl_pkg.sv - register map, status bit positions and FSM states for sim_ctrl
package sim_ctrl_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_CONSOLE  = 3'd1;
  localparam logic [2:0] OFF_CYCLE_LO = 3'd2;
  localparam logic [2:0] OFF_CYCLE_HI = 3'd3;
  localparam logic [2:0] OFF_WDOG     = 3'd4;

  localparam int CTRL_DONE_BIT = 0;
  localparam int CTRL_PASS_BIT = 1;

  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_FAIL    = 2;
  localparam int STAT_TIMEOUT = 3;

  typedef enum logic [1:0] {
    RUN,
    DONE,
    TIMEOUT
  } state_t;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// rtl/sim_ctrl_fifo.sv - synchronous FIFO with wrap-bit pointers
module sim_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the write side lapped the read side.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - memory-mapped simulation control: status, console, cycle counter, watchdog
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 5,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] WDOG_INIT  = 32'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [31:0]       bus_wdata_i,
  output logic              bus_gnt_o,
  output logic              bus_rvalid_o,
  output logic [31:0]       bus_rdata_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic [2:0]      off;
  logic            unused_addr;
  logic            console_wr_req;
  logic            wr_acc;
  logic            rd_acc;
  logic            ctrl_wr;
  logic            wdog_wr;
  logic [63:0]     cycle;
  logic [31:0]     shadow;
  logic [31:0]     reload;
  logic [31:0]     live;
  logic [31:0]     rd_mux;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign off         = bus_addr_i[4:2];
  assign unused_addr = ^bus_addr_i;

  // Only a console write into a full FIFO stalls; gnt never looks at tx_ready_i.
  assign console_wr_req = bus_req_i && bus_we_i && (off == OFF_CONSOLE);
  assign bus_gnt_o      = bus_req_i && !(console_wr_req && fifo_full);
  assign wr_acc         = bus_req_i && bus_gnt_o && bus_we_i;
  assign rd_acc         = bus_req_i && bus_gnt_o && !bus_we_i;
  assign ctrl_wr        = wr_acc && (off == OFF_CTRL);
  assign wdog_wr        = wr_acc && (off == OFF_WDOG);

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'd0 : fifo_dout;

  sim_ctrl_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_acc && (off == OFF_CONSOLE)),
    .pop   (tx_valid_o && tx_ready_i),
    .din   (bus_wdata_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL: begin
        rd_mux[STAT_DONE]    = done_o;
        rd_mux[STAT_PASS]    = pass_o;
        rd_mux[STAT_FAIL]    = fail_o;
        rd_mux[STAT_TIMEOUT] = timeout_o;
      end
      OFF_CONSOLE:  rd_mux = 32'(fifo_count);
      OFF_CYCLE_LO: rd_mux = cycle[31:0];
      OFF_CYCLE_HI: rd_mux = shadow;
      OFF_WDOG:     rd_mux = live;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      bus_rvalid_o <= 1'b0;
      bus_rdata_o  <= '0;
      cycle        <= '0;
      shadow       <= '0;
      reload       <= WDOG_INIT;
      live         <= WDOG_INIT;
    end else begin
      cycle        <= cycle + 64'd1;
      bus_rvalid_o <= rd_acc;
      bus_rdata_o  <= rd_acc ? rd_mux : '0;
      // Latching the high word on the low read keeps a two-read sample coherent.
      if (rd_acc && (off == OFF_CYCLE_LO)) shadow <= cycle[63:32];
      case (state)
        RUN: begin
          if (ctrl_wr && bus_wdata_i[CTRL_DONE_BIT]) begin
            state  <= DONE;
            done_o <= 1'b1;
            pass_o <= bus_wdata_i[CTRL_PASS_BIT];
            fail_o <= !bus_wdata_i[CTRL_PASS_BIT];
          end else if (wdog_wr) begin
            reload <= bus_wdata_i;
            live   <= bus_wdata_i;
          end else if ((reload != 32'd0) && (live != 32'd0)) begin
            live <= live - 32'd1;
            if (live == 32'd1) begin
              state     <= TIMEOUT;
              timeout_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
